// File: rtl/muldiv_unit_if.sv
// Start/busy/done request bus between the core control FSM and the RV32M muldiv unit.
// Operands and funct3 travel with start; result is valid while done is high.
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, funct3, operand_a, operand_b,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, operand_a, operand_b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 RUN iterations + FIX, done after the 33rd edge past accept.
// No backpressure: start is only sampled in IDLE/DONE and ignored while busy.
module muldiv_unit (
  input  logic         clock,
  input  logic         reset_n,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  op;
  logic [31:0] opnd;     // multiplicand or divisor magnitude
  logic [31:0] a_orig;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        neg;
  logic        div0;
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;

  // Operand conditioning at accept time
  logic        a_signed, b_signed, sa, sb, sign_in;
  logic [31:0] a_abs, b_abs;

  always_comb begin
    a_signed = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[0] ^ bus.funct3[1]);
    b_signed = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
    sa       = a_signed & bus.operand_a[31];
    sb       = b_signed & bus.operand_b[31];
    a_abs    = sa ? (32'd0 - bus.operand_a) : bus.operand_a;
    b_abs    = sb ? (32'd0 - bus.operand_b) : bus.operand_b;
    sign_in  = (bus.funct3[2] & bus.funct3[1]) ? sa : (sa ^ sb);
  end

  // One iteration of shift-add (multiply) or restoring division
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [31:0] div_sub;
  logic        div_ge;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 33'd0);
    div_shift = {hi, lo[31]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_sub   = div_shift[31:0] - opnd;
  end

  // Sign fix-up and special cases; signed overflow falls out of the magnitude path naturally
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s, fix_result;

  always_comb begin
    prod_s = neg ? (64'd0 - {hi, lo}) : {hi, lo};
    quo_s  = neg ? (32'd0 - lo) : lo;
    rem_s  = neg ? (32'd0 - hi) : hi;
    if (!op[2])
      fix_result = (op[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
    else if (div0)
      fix_result = op[1] ? a_orig : 32'hFFFF_FFFF;
    else
      fix_result = op[1] ? rem_s : quo_s;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      op       <= 3'd0;
      opnd     <= 32'd0;
      a_orig   <= 32'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      neg      <= 1'b0;
      div0     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          busy_q <= bus.start;
          if (bus.start) begin
            state  <= RUN;
            cnt    <= 5'd0;
            op     <= bus.funct3;
            a_orig <= bus.operand_a;
            neg    <= sign_in;
            div0   <= (bus.operand_b == 32'd0);
            hi     <= 32'd0;
            opnd   <= bus.funct3[2] ? b_abs : a_abs;
            lo     <= bus.funct3[2] ? a_abs : b_abs;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (op[2]) begin
            hi <= div_ge ? div_sub : div_shift[31:0];
            lo <= {lo[30:0], div_ge};
          end else begin
            hi <= mul_sum[32:1];
            lo <= {mul_sum[0], lo[31:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          state    <= DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= fix_result;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: all eight ops, special cases, start filtering,
// back-to-back issue and mid-operation reset, with hand-computed expectations.
module tb_muldiv_unit;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   vectors    = 0;
  int   miscompares = 0;

  muldiv_unit_if bus ();

  muldiv_unit u_dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op (caller sits just after a rising edge), then count edges to done.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n;
    bus.start = 1'b1; bus.funct3 = f; bus.operand_a = a; bus.operand_b = b;
    @(posedge clock); #1;
    bus.start = 1'b0;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!bus.done && n < 40);
    check({tag, "_lat"}, n, 33);
    check({tag, "_res"}, bus.result, exp);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int n, dones, first_n;
    logic [31:0] first_res;

    bus.start = 1'b0; bus.funct3 = 3'd0; bus.operand_a = 32'd0; bus.operand_b = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    @(negedge clock); reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    check("idle_done", {31'd0, bus.done}, 32'd0);

    run_op("mul",      3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulh",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh_neg", 3'b001, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF);
    run_op("div",      3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_op("rem",      3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_op("divu",     3'b101, 32'd100,      32'd7,          32'd14);
    run_op("remu",     3'b111, 32'd100,      32'd7,          32'd2);
    run_op("divu_z",   3'b101, 32'd5,        32'd0,          32'hFFFF_FFFF);
    run_op("remu_z",   3'b111, 32'd5,        32'd0,          32'd5);
    run_op("div_z",    3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
    run_op("rem_z",    3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
    run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Start pulses during RUN (edge 5) and FIX (edge 33) must be ignored
    @(posedge clock); #1;
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.operand_a = 32'd6; bus.operand_b = 32'd7;
    @(posedge clock); #1;
    dones = 0; first_n = 0; first_res = 32'd0;
    for (int k = 1; k <= 45; k++) begin
      bus.start     = (k == 5) || (k == 33);
      bus.funct3    = 3'b101;
      bus.operand_a = 32'd1000;
      bus.operand_b = 32'd3;
      @(posedge clock); #1;
      if (bus.done) begin
        dones++;
        if (dones == 1) begin
          first_n   = k;
          first_res = bus.result;
        end
      end
    end
    bus.start = 1'b0;
    check("ign_dones", dones, 1);
    check("ign_lat", first_n, 33);
    check("ign_res", first_res, 32'd42);
    check("ign_busy", {31'd0, bus.busy}, 32'd0);

    // Back-to-back: new start in the DONE cycle
    run_op("b2b_first", 3'b101, 32'd100, 32'd7, 32'd14);
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.operand_a = 32'd3; bus.operand_b = 32'd5;
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("b2b_done_low", {31'd0, bus.done}, 32'd0);
    check("b2b_busy_high", {31'd0, bus.busy}, 32'd1);
    check("b2b_held", bus.result, 32'd14);
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!bus.done && n < 40);
    check("b2b_lat", n, 33);
    check("b2b_res", bus.result, 32'd15);

    // Reset at iteration 10 of a DIV
    bus.start = 1'b1; bus.funct3 = 3'b100; bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_done", {31'd0, bus.done}, 32'd0);
    check("mid_rst_result", bus.result, 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock); reset_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (bus.done) dones++;
    end
    check("mid_rst_no_done", dones, 0);
    run_op("post_rst_div", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
